// File: rtl/reservation_station.sv
// Reservation station for ALU-class instructions: buffers dispatched ops,
// snoops both CDBs for operand wakeup, and issues one ready op per cycle.
module reservation_station #(
  parameter int RS_SIZE    = 16,
  parameter int ROB_LEN    = 4,
  parameter int DATA_LEN   = 32,
  parameter int ADDR_LEN   = 32,
  parameter int OPENUM_LEN = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  ena_from_dsp,
  input  logic [OPENUM_LEN-1:0] openum_from_dsp,
  input  logic [DATA_LEN-1:0]   V1_from_dsp,
  input  logic [DATA_LEN-1:0]   V2_from_dsp,
  input  logic [ROB_LEN:0]      Q1_from_dsp,
  input  logic [ROB_LEN:0]      Q2_from_dsp,
  input  logic [ADDR_LEN-1:0]   pc_from_dsp,
  input  logic [ADDR_LEN-1:0]   imm_from_dsp,
  input  logic [ROB_LEN:0]      rob_id_from_dsp,
  input  logic                  valid_from_alu_cdb,
  input  logic [ROB_LEN:0]      rob_id_from_alu_cdb,
  input  logic [DATA_LEN-1:0]   result_from_alu_cdb,
  input  logic                  valid_from_lsb_cdb,
  input  logic [ROB_LEN:0]      rob_id_from_lsb_cdb,
  input  logic [DATA_LEN-1:0]   result_from_lsb_cdb,
  input  logic                  rollback_from_rob,
  output logic                  full_to_if,
  output logic                  ena_to_alu,
  output logic [OPENUM_LEN-1:0] openum_to_alu,
  output logic [DATA_LEN-1:0]   V1_to_alu,
  output logic [DATA_LEN-1:0]   V2_to_alu,
  output logic [ADDR_LEN-1:0]   pc_to_alu,
  output logic [ADDR_LEN-1:0]   imm_to_alu,
  output logic [ROB_LEN:0]      rob_id_to_alu
);

  localparam int IDX = $clog2(RS_SIZE);
  localparam int TAG = ROB_LEN + 1;

  logic [RS_SIZE-1:0]    busy;
  logic [OPENUM_LEN-1:0] openum [RS_SIZE];
  logic [DATA_LEN-1:0]   V1     [RS_SIZE];
  logic [DATA_LEN-1:0]   V2     [RS_SIZE];
  logic [TAG-1:0]        Q1     [RS_SIZE];
  logic [TAG-1:0]        Q2     [RS_SIZE];
  logic [ADDR_LEN-1:0]   pc     [RS_SIZE];
  logic [ADDR_LEN-1:0]   imm    [RS_SIZE];
  logic [TAG-1:0]        rob_id [RS_SIZE];

  logic                  free_found;
  logic [IDX-1:0]        free_idx;
  logic [IDX:0]          free_cnt;
  logic                  issue_found;
  logic [IDX-1:0]        issue_idx;

  logic [DATA_LEN-1:0]   wake_V1 [RS_SIZE];
  logic [DATA_LEN-1:0]   wake_V2 [RS_SIZE];
  logic [TAG-1:0]        wake_Q1 [RS_SIZE];
  logic [TAG-1:0]        wake_Q2 [RS_SIZE];
  logic [DATA_LEN-1:0]   ins_V1, ins_V2;
  logic [TAG-1:0]        ins_Q1, ins_Q2;

  // Returns {tag, value} after snooping both CDBs; ALU CDB wins on a tie.
  function automatic logic [TAG+DATA_LEN-1:0] snoop(
    input logic [TAG-1:0]      q,
    input logic [DATA_LEN-1:0] v,
    input logic                alu_vld,
    input logic [TAG-1:0]      alu_tag,
    input logic [DATA_LEN-1:0] alu_res,
    input logic                lsb_vld,
    input logic [TAG-1:0]      lsb_tag,
    input logic [DATA_LEN-1:0] lsb_res
  );
    if (q != '0 && alu_vld && alu_tag == q)
      return {{TAG{1'b0}}, alu_res};
    else if (q != '0 && lsb_vld && lsb_tag == q)
      return {{TAG{1'b0}}, lsb_res};
    else
      return {q, v};
  endfunction

  always_comb begin
    free_found  = 1'b0;
    free_idx    = '0;
    free_cnt    = '0;
    issue_found = 1'b0;
    issue_idx   = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      if (!busy[i]) begin
        free_cnt = free_cnt + (IDX+1)'(1);
        if (!free_found) begin
          free_found = 1'b1;
          free_idx   = IDX'(i);
        end
      end else if (Q1[i] == '0 && Q2[i] == '0 && !issue_found) begin
        issue_found = 1'b1;
        issue_idx   = IDX'(i);
      end
    end
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      {wake_Q1[i], wake_V1[i]} = snoop(Q1[i], V1[i],
        valid_from_alu_cdb, rob_id_from_alu_cdb, result_from_alu_cdb,
        valid_from_lsb_cdb, rob_id_from_lsb_cdb, result_from_lsb_cdb);
      {wake_Q2[i], wake_V2[i]} = snoop(Q2[i], V2[i],
        valid_from_alu_cdb, rob_id_from_alu_cdb, result_from_alu_cdb,
        valid_from_lsb_cdb, rob_id_from_lsb_cdb, result_from_lsb_cdb);
    end
    {ins_Q1, ins_V1} = snoop(Q1_from_dsp, V1_from_dsp,
      valid_from_alu_cdb, rob_id_from_alu_cdb, result_from_alu_cdb,
      valid_from_lsb_cdb, rob_id_from_lsb_cdb, result_from_lsb_cdb);
    {ins_Q2, ins_V2} = snoop(Q2_from_dsp, V2_from_dsp,
      valid_from_alu_cdb, rob_id_from_alu_cdb, result_from_alu_cdb,
      valid_from_lsb_cdb, rob_id_from_lsb_cdb, result_from_lsb_cdb);
  end

  // Two free slots are needed to absorb the dispatcher's one-cycle register slack.
  assign full_to_if = (free_cnt < (IDX+1)'(2));

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy          <= '0;
      ena_to_alu    <= 1'b0;
      openum_to_alu <= '0;
      V1_to_alu     <= '0;
      V2_to_alu     <= '0;
      pc_to_alu     <= '0;
      imm_to_alu    <= '0;
      rob_id_to_alu <= '0;
    end else if (rdy) begin
      if (rollback_from_rob) begin
        busy       <= '0;
        ena_to_alu <= 1'b0;
      end else begin
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
          Q1[i] <= wake_Q1[i];
          V1[i] <= wake_V1[i];
          Q2[i] <= wake_Q2[i];
          V2[i] <= wake_V2[i];
        end
        ena_to_alu <= issue_found;
        if (issue_found) begin
          busy[issue_idx] <= 1'b0;
          openum_to_alu   <= openum[issue_idx];
          V1_to_alu       <= V1[issue_idx];
          V2_to_alu       <= V2[issue_idx];
          pc_to_alu       <= pc[issue_idx];
          imm_to_alu      <= imm[issue_idx];
          rob_id_to_alu   <= rob_id[issue_idx];
        end
        // The free slot is never the issuing slot, so both writes can coexist.
        if (ena_from_dsp && free_found) begin
          busy[free_idx]   <= 1'b1;
          openum[free_idx] <= openum_from_dsp;
          V1[free_idx]     <= ins_V1;
          V2[free_idx]     <= ins_V2;
          Q1[free_idx]     <= ins_Q1;
          Q2[free_idx]     <= ins_Q2;
          pc[free_idx]     <= pc_from_dsp;
          imm[free_idx]    <= imm_from_dsp;
          rob_id[free_idx] <= rob_id_from_dsp;
        end
      end
    end
  end

endmodule
